// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg: stream FSM encoding and raster geometry helpers shared by the LCD timing path
package lcd_timing_pkg;
  typedef enum logic [1:0] {SEEK, WAIT, RUN} state_t;
  function automatic int tot(input int act, fp, sync, bp);
    return act + fp + sync + bp;
  endfunction
  function automatic int sync_start(input int act, fp);
    return act + fp;
  endfunction
endpackage

// File: rtl/lcd_raster_cnt.sv
// lcd_raster_cnt: free-running H/V raster counters with active-area and sync-window decode
module lcd_raster_cnt
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 21
) (
  input  logic clk,
  input  logic rst,
  output logic active,
  output logic hs_on,
  output logic vs_on,
  output logic first,
  output logic frame_end
);
  localparam int H_TOT = tot(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = tot(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int H_SYNC_START = sync_start(H_ACTIVE, H_FP);
  localparam int V_SYNC_START = sync_start(V_ACTIVE, V_FP);
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic h_end, v_end;
  always_comb begin
    h_end = h_cnt == HW'(H_TOT - 1);
    v_end = v_cnt == VW'(V_TOT - 1);
    active = int'(h_cnt) < H_ACTIVE && int'(v_cnt) < V_ACTIVE;
    hs_on = int'(h_cnt) >= H_SYNC_START && int'(h_cnt) < H_SYNC_START + H_SYNC;
    vs_on = int'(v_cnt) >= V_SYNC_START && int'(v_cnt) < V_SYNC_START + V_SYNC;
    first = h_cnt == '0 && v_cnt == '0;
    frame_end = h_end && v_end;
  end
  always_ff @(posedge clk)
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_end ? '0 : h_cnt + 1'b1;
      if (h_end) v_cnt <= v_end ? '0 : v_cnt + 1'b1;
    end
endmodule

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: LCD raster generator that pulls pixels from an AXI-stream and locks frames to TUSER
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 21,
  parameter logic SYNC_POL = 1'b0,
  parameter logic [DATA_W-1:0] BG_COLOR = '0
) (
  input  logic              axis_aclk,
  input  logic              axis_areset,
  input  logic              enable,
  input  logic              axis_data_en,
  input  logic              axis_data_sync,
  input  logic [DATA_W-1:0] axis_tdata,
  output logic              axis_data_requst,
  output logic              lcd_hs,
  output logic              lcd_vs,
  output logic              lcd_de,
  output logic [DATA_W-1:0] lcd_data,
  output logic              frame_start,
  output logic              underflow,
  output logic              sync_err
);
  state_t state;
  logic idle, active, hs_on, vs_on, first, frame_end, run_px, bad_sync, good;
  assign idle = axis_areset | ~enable;
  lcd_raster_cnt #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_raster (
    .clk(axis_aclk), .rst(idle), .active(active), .hs_on(hs_on), .vs_on(vs_on),
    .first(first), .frame_end(frame_end)
  );
  // A frame's first pixel must carry sync; anywhere else a sync beat is held back for the next frame
  always_comb begin
    run_px = state == RUN && active;
    bad_sync = axis_data_en & (first ? ~axis_data_sync : axis_data_sync);
    good = axis_data_en & ~bad_sync;
    axis_data_requst = idle ? 1'b0
                     : state == SEEK ? ~(axis_data_en & axis_data_sync)
                     : run_px & (first | ~axis_data_sync);
  end
  always_ff @(posedge axis_aclk)
    if (idle) begin
      state <= SEEK;
      lcd_hs <= ~SYNC_POL;
      lcd_vs <= ~SYNC_POL;
      lcd_de <= 1'b0;
      lcd_data <= BG_COLOR;
      frame_start <= 1'b0;
      underflow <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      lcd_hs <= hs_on ? SYNC_POL : ~SYNC_POL;
      lcd_vs <= vs_on ? SYNC_POL : ~SYNC_POL;
      lcd_de <= run_px;
      lcd_data <= run_px && good ? axis_tdata : BG_COLOR;
      frame_start <= run_px && first && good;
      underflow <= run_px && !axis_data_en;
      sync_err <= run_px && bad_sync;
      state <= state == SEEK ? (axis_data_en && axis_data_sync ? WAIT : SEEK)
             : state == WAIT ? (frame_end ? RUN : WAIT)
             : run_px && bad_sync ? (first ? SEEK : WAIT) : RUN;
    end
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: directed raster/handshake vectors on a 14x7 raster with a queued beat source
module tb_lcd_timing_gen;
  localparam int DW = 24;
  logic clk = 1'b0;
  logic areset, enable, data_en, data_sync, requst, hs, vs, de, fs, uf, se;
  logic [DW-1:0] tdata, ldata;
  always #5 clk = ~clk;

  lcd_timing_gen #(
    .DATA_W(DW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .axis_aclk(clk), .axis_areset(areset), .enable(enable), .axis_data_en(data_en),
    .axis_data_sync(data_sync), .axis_tdata(tdata), .axis_data_requst(requst),
    .lcd_hs(hs), .lcd_vs(vs), .lcd_de(de), .lcd_data(ldata),
    .frame_start(fs), .underflow(uf), .sync_err(se)
  );

  typedef struct {logic [DW-1:0] data; logic sync;} beat_t;
  typedef struct {int k; logic de, hs, vs, fs; logic [DW-1:0] data;} vec_t;
  beat_t q[$];
  vec_t tbl[$];
  int total = 0, bad = 0, k = 0, n_de, n_fs, n_uf, n_se;
  logic gap = 1'b0, take = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic push_frame(input int n, input logic [DW-1:0] v0, input logic sync0);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = v0 + DW'(i);
      b.sync = sync0 && i == 0;
      q.push_back(b);
    end
  endtask

  task automatic add(input int kk, input logic d, h, v, f, input logic [DW-1:0] x);
    vec_t e;
    e.k = kk; e.de = d; e.hs = h; e.vs = v; e.fs = f; e.data = x;
    tbl.push_back(e);
  endtask

  task automatic clr_counts();
    k = 0; n_de = 0; n_fs = 0; n_uf = 0; n_se = 0;
  endtask

  // One raster cycle: present queue head, sample handshake, then read the registered outputs
  task automatic tick();
    data_en = !gap && q.size() > 0;
    data_sync = q.size() > 0 ? q[0].sync : 1'b0;
    tdata = q.size() > 0 ? q[0].data : '0;
    #1 take = requst && data_en;
    @(posedge clk);
    #1;
    if (take) void'(q.pop_front());
    n_de += int'(de); n_fs += int'(fs); n_uf += int'(uf); n_se += int'(se);
    k++;
  endtask

  task automatic do_reset(input int n);
    areset = 1'b1; enable = 1'b1; gap = 1'b0;
    data_en = 1'b0; data_sync = 1'b0; tdata = '0;
    q.delete();
    repeat (n) @(posedge clk);
    #1 areset = 1'b0;
    clr_counts();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    add(0, 0, 1, 1, 0, 'h0);   add(9, 0, 1, 1, 0, 'h0);   add(10, 0, 0, 1, 0, 'h0);
    add(11, 0, 0, 1, 0, 'h0);  add(12, 0, 1, 1, 0, 'h0);  add(69, 0, 1, 1, 0, 'h0);
    add(70, 0, 1, 0, 0, 'h0);  add(80, 0, 0, 0, 0, 'h0);  add(84, 0, 1, 1, 0, 'h0);
    add(98, 1, 1, 1, 1, 'h01); add(99, 1, 1, 1, 0, 'h02); add(105, 1, 1, 1, 0, 'h08);
    add(106, 0, 1, 1, 0, 'h0); add(108, 0, 0, 1, 0, 'h0); add(112, 1, 1, 1, 0, 'h09);
    add(147, 1, 1, 1, 0, 'h20); add(148, 0, 1, 1, 0, 'h0); add(154, 0, 1, 1, 0, 'h0);
    add(196, 1, 1, 1, 1, 'h01); add(197, 1, 1, 1, 0, 'h02);

    // reset held 3 cycles
    areset = 1'b1; enable = 1'b1; data_en = 1'b0; data_sync = 1'b0; tdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_de", de, 0); chk("rst_hs", hs, 1); chk("rst_vs", vs, 1);
    chk("rst_requst", requst, 0); chk("rst_data", ldata, 0);
    chk("rst_pulses", {fs, uf, se}, 0);
    areset = 1'b0;
    chk("rst_hcnt", dut.u_raster.h_cnt, 0); chk("rst_vcnt", dut.u_raster.v_cnt, 0);

    // clean stream, table-driven raster checks
    do_reset(2);
    repeat (3) push_frame(32, 'h01, 1'b1);
    for (int c = 0; c < 200; c++) begin
      tick();
      foreach (tbl[i]) if (tbl[i].k == c) begin
        chk($sformatf("t2_de@%0d", c), de, tbl[i].de);
        chk($sformatf("t2_hs@%0d", c), hs, tbl[i].hs);
        chk($sformatf("t2_vs@%0d", c), vs, tbl[i].vs);
        chk($sformatf("t2_fs@%0d", c), fs, tbl[i].fs);
        chk($sformatf("t2_data@%0d", c), ldata, tbl[i].data);
      end
    end
    chk("t2_de_count", n_de, 36); chk("t2_fs_count", n_fs, 2);
    chk("t2_uf_count", n_uf, 0); chk("t2_se_count", n_se, 0);

    // junk beats before sync are discarded in SEEK
    do_reset(2);
    push_frame(5, 'hA0, 1'b0);
    repeat (2) push_frame(32, 'h01, 1'b1);
    repeat (5) tick();
    chk("t3_junk_consumed", q.size(), 64);
    tick();
    chk("t3_sync_held", take, 0);
    while (k < 99) tick();
    chk("t3_first_de", de, 1); chk("t3_first_fs", fs, 1); chk("t3_first_data", ldata, 'h01);
    chk("t3_de_count", n_de, 1);

    // one-cycle data_en drop at pixel 3 of line 1
    while (k < 115) tick();
    gap = 1'b1;
    tick();
    gap = 1'b0;
    chk("t4_uf", uf, 1); chk("t4_uf_de", de, 1); chk("t4_uf_data", ldata, 0);
    tick();
    chk("t4_next_data", ldata, 'h0c); chk("t4_next_uf", uf, 0);
    while (k < 131) tick();
    chk("t4_uf_count", n_uf, 1); chk("t4_se_count", n_se, 0);

    // sync beat arriving at pixel 20
    do_reset(2);
    push_frame(20, 'h01, 1'b1);
    repeat (2) push_frame(32, 'h01, 1'b1);
    while (k < 131) tick();
    chk("t5_se", se, 1); chk("t5_se_de", de, 1); chk("t5_se_data", ldata, 0);
    chk("t5_not_taken", take, 0);
    tick();
    chk("t5_wait_de", de, 0);
    while (k < 197) tick();
    chk("t5_relock_fs", fs, 1); chk("t5_relock_data", ldata, 'h01);
    chk("t5_se_count", n_se, 1);

    // enable low mid-line for 4 cycles, then SEEK relock
    while (k < 200) tick();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t6_idle_de%0d", i), de, 0);
      chk($sformatf("t6_idle_data%0d", i), ldata, 0);
      chk($sformatf("t6_idle_req%0d", i), take, 0);
    end
    enable = 1'b1;
    clr_counts();
    while (k < 99) tick();
    chk("t6_relock_fs", fs, 1); chk("t6_relock_data", ldata, 'h01);
    chk("t6_de_count", n_de, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
